// File: rtl/ans_encoder_pkg.sv
// rtl/ans_encoder_pkg.sv - shared defaults and FSM encoding for the rANS encoder (package ans_pkg)
package ans_pkg;

  localparam int SYM_WIDTH_DEF   = 4;
  localparam int CNT_WIDTH_DEF   = 4;
  localparam int SYM_COUNT_DEF   = 16;
  localparam int STATE_WIDTH_DEF = 16;

  localparam logic [2:0] ENC_READ   = 3'd0;
  localparam logic [2:0] ENC_RENORM = 3'd1;
  localparam logic [2:0] ENC_DIV    = 3'd2;
  localparam logic [2:0] ENC_COMMIT = 3'd3;
  localparam logic [2:0] ENC_FLUSH  = 3'd4;

  typedef enum logic [2:0] {
    ST_READ   = ENC_READ,
    ST_RENORM = ENC_RENORM,
    ST_DIV    = ENC_DIV,
    ST_COMMIT = ENC_COMMIT,
    ST_FLUSH  = ENC_FLUSH
  } enc_state_e;

endpackage

// File: rtl/ans_encoder_if.sv
// rtl/ans_encoder_if.sv - symbol-in / nibble-out handshake bundle of the rANS encoder
interface ans_encoder_if #(
  parameter int SYM_WIDTH = ans_pkg::SYM_WIDTH_DEF
);

  logic [SYM_WIDTH-1:0] in;
  logic                 in_last;
  logic                 in_vld;
  logic                 in_rdy;
  logic [SYM_WIDTH-1:0] out;
  logic                 out_vld;
  logic                 out_rdy;
  logic                 done;
  logic                 err;

  modport master (
    output in, in_last, in_vld, out_rdy,
    input  in_rdy, out, out_vld, done, err
  );

  modport slave (
    input  in, in_last, in_vld, out_rdy,
    output in_rdy, out, out_vld, done, err
  );

endinterface

// File: rtl/ans_enc_divmod.sv
// rtl/ans_enc_divmod.sv - sequential radix-2 restoring divider, one quotient bit per cycle
module ans_enc_divmod #(
  parameter int W  = 16,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          start,
  input  logic [W-1:0]  dividend,
  input  logic [DW-1:0] divisor,
  output logic          done,
  output logic [W-1:0]  quotient,
  output logic [W-1:0]  remainder
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  quo_q;
  logic [W-1:0]  rem_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;

  logic [W:0]    shifted;
  logic [W:0]    dvs_ext;
  logic          ge;
  logic [W:0]    rem_next;

  // One restoring step: bring down the next dividend bit and subtract if it fits
  always_comb begin
    shifted  = {rem_q, quo_q[W-1]};
    dvs_ext  = {{(W + 1 - DW){1'b0}}, divisor};
    ge       = (shifted >= dvs_ext);
    rem_next = ge ? (shifted - dvs_ext) : shifted;
  end

  // Load on start, then iterate W times; done pulses once the last bit is resolved
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (ena) begin
      done_q <= 1'b0;
      if (start && !busy_q) begin
        quo_q  <= dividend;
        rem_q  <= '0;
        cnt_q  <= CW'(W);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        quo_q <= {quo_q[W-2:0], ge};
        rem_q <= rem_next[W-1:0];
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/ans_encoder.sv
// rtl/ans_encoder.sv - streaming rANS encoder top; optional feature macro ANS_ENC_ZERO_CHECK_EN
module ans_encoder
  import ans_pkg::*;
#(
  parameter int SYM_WIDTH   = SYM_WIDTH_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int SYM_COUNT   = SYM_COUNT_DEF,
  parameter int STATE_WIDTH = STATE_WIDTH_DEF
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     ena,
  input  logic [CNT_WIDTH*SYM_COUNT-1:0]           counts_unpacked,
  input  logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] cumulative_unpacked,
  ans_encoder_if.slave                             bus
);

  localparam int CUM_W   = CNT_WIDTH + SYM_WIDTH;
  localparam int NIBBLES = STATE_WIDTH / SYM_WIDTH;
  localparam int FL_W    = $clog2(NIBBLES + 1);

  enc_state_e              state_q;
  logic [STATE_WIDTH-1:0]  x_q;
  logic                    fresh_q;
  logic [SYM_WIDTH-1:0]    sym_q;
  logic                    last_q;
  logic [FL_W-1:0]         fl_cnt_q;
  logic                    done_q;
  logic                    err_q;

  logic [CNT_WIDTH-1:0]    count_tab [SYM_COUNT];
  logic [CUM_W-1:0]        start_tab [SYM_COUNT];
  logic [CUM_W-1:0]        m_tot;
  logic [CNT_WIDTH-1:0]    cnt_sym;
  logic [STATE_WIDTH-1:0]  m_ext;
  logic [STATE_WIDTH-1:0]  start_ext;
  logic [STATE_WIDTH-1:0]  x_eff;
  logic [STATE_WIDTH-1:0]  thr;
  logic [STATE_WIDTH-1:0]  x_new;
  logic                    renorm_go;
  logic                    drop_sym;
  logic                    div_start;
  logic                    div_done;
  logic [STATE_WIDTH-1:0]  div_q;
  logic [STATE_WIDTH-1:0]  div_r;

  assign start_tab[0] = '0;
  for (genvar g = 0; g < SYM_COUNT; g++) begin : g_tab
    assign count_tab[g] = counts_unpacked[g*CNT_WIDTH +: CNT_WIDTH];
    if (g > 0) begin : g_start
      assign start_tab[g] = cumulative_unpacked[(g-1)*CUM_W +: CUM_W];
    end
  end

  assign m_tot     = cumulative_unpacked[(SYM_COUNT-1)*CUM_W +: CUM_W];
  assign m_ext     = STATE_WIDTH'(m_tot);
  assign cnt_sym   = count_tab[sym_q];
  assign start_ext = STATE_WIDTH'(start_tab[sym_q]);
  // A fresh stream starts from x = M without needing an asynchronous load of a table input
  assign x_eff     = fresh_q ? m_ext : x_q;
  assign thr       = STATE_WIDTH'(cnt_sym) << SYM_WIDTH;
  assign renorm_go = (x_q >= thr);
  // q < 16 after renormalisation, so q*M + start + r stays below 16*M and fits the state width
  assign x_new     = div_q * m_ext + start_ext + div_r;
  assign div_start = ena && (state_q == ST_RENORM) && !renorm_go;

`ifdef ANS_ENC_ZERO_CHECK_EN
  assign drop_sym = (count_tab[bus.in] == '0);
`else
  assign drop_sym = 1'b0;
`endif

  ans_enc_divmod #(
    .W  (STATE_WIDTH),
    .DW (CNT_WIDTH)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .start     (div_start),
    .dividend  (x_q),
    .divisor   (cnt_sym),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign bus.in_rdy  = (state_q == ST_READ);
  assign bus.out_vld = ((state_q == ST_RENORM) && renorm_go) || (state_q == ST_FLUSH);
  assign bus.out     = (state_q == ST_RENORM) ? x_q[SYM_WIDTH-1:0] :
                       (state_q == ST_FLUSH)  ? x_q[STATE_WIDTH-1 -: SYM_WIDTH] : '0;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

  // Encoder sequencing: read symbol, shed low nibbles, divide, fold into state, flush at end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_READ;
      x_q      <= '0;
      fresh_q  <= 1'b1;
      sym_q    <= '0;
      last_q   <= 1'b0;
      fl_cnt_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (ena) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_READ: begin
          if (bus.in_vld) begin
            x_q     <= x_eff;
            fresh_q <= 1'b0;
            if (drop_sym) begin
              err_q <= 1'b1;
              if (bus.in_last) begin
                fl_cnt_q <= '0;
                state_q  <= ST_FLUSH;
              end
            end else begin
              sym_q   <= bus.in;
              last_q  <= bus.in_last;
              state_q <= ST_RENORM;
            end
          end
        end
        ST_RENORM: begin
          if (renorm_go) begin
            if (bus.out_rdy) x_q <= x_q >> SYM_WIDTH;
          end else begin
            state_q <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (div_done) state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          x_q      <= x_new;
          fl_cnt_q <= '0;
          state_q  <= last_q ? ST_FLUSH : ST_READ;
        end
        ST_FLUSH: begin
          if (bus.out_rdy) begin
            x_q <= x_q << SYM_WIDTH;
            if (fl_cnt_q == FL_W'(NIBBLES - 1)) begin
              fl_cnt_q <= '0;
              done_q   <= 1'b1;
              fresh_q  <= 1'b1;
              state_q  <= ST_READ;
            end else begin
              fl_cnt_q <= fl_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_READ;
      endcase
    end
  end

endmodule

// File: tb/tb_ans_encoder.sv
// tb/tb_ans_encoder.sv - self-checking bench for ans_encoder with rANS reference encoder and decoder
module tb_ans_encoder;

  logic         clk;
  logic         rst;
  logic         ena;
  logic [63:0]  counts_unpacked;
  logic [127:0] cumulative_unpacked;

  ans_encoder_if #(.SYM_WIDTH(4)) bus ();

  ans_encoder dut (
    .clk                 (clk),
    .rst                 (rst),
    .ena                 (ena),
    .counts_unpacked     (counts_unpacked),
    .cumulative_unpacked (cumulative_unpacked),
    .bus                 (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  int f  [16];
  int cs [16];
  int m_tot;
  int tx_syms [$];
  int rx_nib  [$];
  int exp_nib [$];
  int err_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic load_tables();
    int run;
    run = 0;
    for (int j = 0; j < 16; j++) begin
      cs[j] = run;
      run   = run + f[j];
      counts_unpacked[j*4 +: 4]     = 4'(f[j]);
      cumulative_unpacked[j*8 +: 8] = 8'(run);
    end
    m_tot = run;
  endtask

  task automatic spec_tables();
    for (int j = 0; j < 16; j++) f[j] = 0;
    f[0] = 8; f[1] = 4; f[2] = 2; f[3] = 2;
    load_tables();
  endtask

  // Textbook rANS: renormalise against 16*f[s], then x' = (x/f)*M + start + x%f; flush MSB first
  function automatic void ref_encode();
    longint x;
    int s;
    x = m_tot;
    exp_nib.delete();
    foreach (tx_syms[k]) begin
      s = tx_syms[k];
      while (x >= 16 * f[s]) begin
        exp_nib.push_back(int'(x % 16));
        x = x / 16;
      end
      x = (x / f[s]) * m_tot + cs[s] + (x % f[s]);
    end
    for (int i = 3; i >= 0; i--) exp_nib.push_back(int'((x >> (4 * i)) % 16));
  endfunction

  // Decode the reversed captured stream and count symbols that do not come back
  function automatic int decode_bad();
    int rev [$];
    longint x;
    int p, bad, slot, s;
    for (int i = rx_nib.size() - 1; i >= 0; i--) rev.push_back(rx_nib[i]);
    if (rev.size() < 4) return 1000;
    x = rev[0] + rev[1] * 16 + rev[2] * 256 + rev[3] * 4096;
    p = 4;
    bad = 0;
    for (int k = tx_syms.size() - 1; k >= 0; k--) begin
      slot = int'(x % m_tot);
      s = -1;
      for (int j = 0; j < 16; j++)
        if (f[j] > 0 && slot >= cs[j] && slot < cs[j] + f[j]) s = j;
      if (s < 0) return bad + 1000;
      if (s != tx_syms[k]) bad++;
      x = f[s] * (x / m_tot) + slot - cs[s];
      while (x < m_tot && p < rev.size()) begin
        x = x * 16 + rev[p];
        p++;
      end
    end
    if (x != m_tot || p != rev.size()) bad++;
    return bad;
  endfunction

  // Cycle loop: drive at posedge+1, observe at negedge. mode 0 ready, 1 random, 2 stall first nibble 5 cycles
  task automatic run_stream(input string tag, input int mode, input bit ena_gap, input int abort_at,
                            output bit got_done);
    int idx, acc_cyc, stall_cnt;
    bit prev_stall;
    logic [3:0] prev_out;
    idx = 0; acc_cyc = -1; stall_cnt = 0; prev_stall = 0; prev_out = '0;
    got_done = 0;
    err_cnt  = 0;
    rx_nib.delete();
    for (int cyc = 0; cyc < 4000 && !got_done; cyc++) begin
      bus.in_vld  = (idx < tx_syms.size());
      bus.in      = (idx < tx_syms.size()) ? 4'(tx_syms[idx]) : 4'd0;
      bus.in_last = (idx == tx_syms.size() - 1);
      ena = !(ena_gap && acc_cyc >= 0 && (cyc - acc_cyc) >= 5 && (cyc - acc_cyc) < 15);
      case (mode)
        1:       bus.out_rdy = 1'($urandom_range(0, 1));
        2:       bus.out_rdy = (rx_nib.size() > 0) || (stall_cnt >= 5);
        default: bus.out_rdy = 1'b1;
      endcase
      @(negedge clk);
      if (prev_stall) begin
        check({tag, "_hold_vld"}, 64'(bus.out_vld), 64'd1);
        check({tag, "_hold_out"}, 64'(bus.out), 64'(prev_out));
      end
      prev_stall = bus.out_vld && !(bus.out_rdy && ena);
      prev_out   = bus.out;
      if (bus.in_vld && bus.in_rdy && ena) begin
        idx++;
        if (acc_cyc < 0) acc_cyc = cyc;
      end
      if (bus.out_vld && bus.out_rdy && ena) rx_nib.push_back(int'(bus.out));
      if (mode == 2 && bus.out_vld && rx_nib.size() == 0 && ena) stall_cnt++;
      if (bus.err) err_cnt++;
      if (bus.done) got_done = 1;
      if (abort_at > 0 && rx_nib.size() == abort_at) break;
      @(posedge clk);
      #1;
    end
    ena = 1'b1;
  endtask

  task automatic do_stream(input string tag, input int mode, input bit ena_gap,
                           input int exp_err, input bit dec);
    bit got_done;
    int nbad;
    run_stream(tag, mode, ena_gap, 0, got_done);
    check({tag, "_done"}, 64'(got_done), 64'd1);
    check({tag, "_len"}, 64'(rx_nib.size()), 64'(exp_nib.size()));
    nbad = 0;
    for (int i = 0; i < rx_nib.size() && i < exp_nib.size(); i++)
      if (rx_nib[i] != exp_nib[i]) nbad++;
    check({tag, "_nibbles_wrong"}, 64'(nbad), 64'd0);
    check({tag, "_err_pulses"}, 64'(err_cnt), 64'(exp_err));
    if (dec) check({tag, "_decode_wrong"}, 64'(decode_bad()), 64'd0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(bus.done), 64'd0);
    check({tag, "_in_rdy_after"}, 64'(bus.in_rdy), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit got_done;
    int len;
    rst = 1'b1;
    ena = 1'b1;
    bus.in = '0; bus.in_vld = 1'b0; bus.in_last = 1'b0; bus.out_rdy = 1'b0;
    counts_unpacked = '0;
    cumulative_unpacked = '0;
    spec_tables();

    repeat (2) @(negedge clk);
    check("rst_in_rdy", 64'(bus.in_rdy), 64'd1);
    check("rst_out_vld", 64'(bus.out_vld), 64'd0);
    check("rst_out", 64'(bus.out), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    tx_syms = '{0, 1, 3};
    exp_nib = '{8, 0, 0, 4, 14};
    do_stream("s013", 0, 1'b0, 0, 1'b1);

    tx_syms = '{0};
    exp_nib = '{0, 0, 2, 0};
    do_stream("s0", 0, 1'b0, 0, 1'b1);

    tx_syms = '{0, 1, 3};
    exp_nib = '{8, 0, 0, 4, 14};
    do_stream("s013_stall", 2, 1'b0, 0, 1'b1);

    tx_syms = '{0, 1, 3};
    exp_nib = '{8, 0, 0, 4, 14};
    do_stream("s013_ena_gap", 0, 1'b1, 0, 1'b1);

    tx_syms = '{0, 1, 3};
    run_stream("flush_abort", 0, 1'b0, 2, got_done);
    check("flush_abort_reached", 64'(rx_nib.size()), 64'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_out_vld", 64'(bus.out_vld), 64'd0);
    check("mid_rst_in_rdy", 64'(bus.in_rdy), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_vld", 64'(bus.out_vld), 64'd0);
    check("post_rst_in_rdy", 64'(bus.in_rdy), 64'd1);
    @(posedge clk); #1;
    tx_syms = '{0};
    exp_nib = '{0, 0, 2, 0};
    do_stream("after_rst", 0, 1'b0, 0, 1'b1);

`ifdef ANS_ENC_ZERO_CHECK_EN
    tx_syms = '{0, 5, 1, 3};
    exp_nib = '{8, 0, 0, 4, 14};
    do_stream("zero_mid", 0, 1'b0, 1, 1'b0);
    tx_syms = '{0, 5};
    exp_nib = '{0, 0, 2, 0};
    do_stream("zero_last", 0, 1'b0, 1, 1'b0);
`endif

    for (int t = 0; t < 12; t++) begin
      if (t % 4 == 0) begin
        for (int j = 0; j < 16; j++) f[j] = int'($urandom_range(1, 15));
        load_tables();
      end
      len = int'($urandom_range(1, 8));
      tx_syms.delete();
      for (int k = 0; k < len; k++) tx_syms.push_back(int'($urandom_range(0, 15)));
      ref_encode();
      do_stream($sformatf("rand%0d", t), int'($urandom_range(0, 1)), 1'b0, 0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
